// File: rtl/regfile_write_scheduler_if.sv
// Writeback request bundle: two valid/ready requesters feeding the register file write port.
// The master side is the requester pair; the slave side is the scheduler.
interface regfile_write_scheduler_if #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ADDR_W = 5
);
   logic              req0_valid;
   logic [ADDR_W-1:0] req0_rd;
   logic [DATA_W-1:0] req0_data;
   logic              req0_ready;
   logic              req1_valid;
   logic [ADDR_W-1:0] req1_rd;
   logic [DATA_W-1:0] req1_data;
   logic              req1_ready;

   modport master (
      output req0_valid, req0_rd, req0_data,
      output req1_valid, req1_rd, req1_data,
      input  req0_ready, req1_ready
   );

   modport slave (
      input  req0_valid, req0_rd, req0_data,
      input  req1_valid, req1_rd, req1_data,
      output req0_ready, req1_ready
   );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Owns the register file write port: sweeps INIT_VALUE into every register after
// reset, then arbitrates round-robin between two writeback requesters.
module regfile_write_scheduler #(
   parameter int unsigned       DATA_W     = 64,
   parameter int unsigned       ADDR_W     = 5,
   parameter int unsigned       NREGS      = 32,
   parameter logic [DATA_W-1:0] INIT_VALUE = '0,
   parameter bit                ZERO_X0    = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset,
   regfile_write_scheduler_if.slave  wb,
   output logic                      rf_RegWrite,
   output logic [ADDR_W-1:0]         rf_RD,
   output logic [DATA_W-1:0]         rf_WriteData,
   output logic                      init_done
);

   typedef enum logic {INIT, RUN} state_t;

   localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NREGS - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              last_grant_q, last_grant_d;
   logic              regwrite_q, regwrite_d;
   logic [ADDR_W-1:0] rd_q, rd_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              init_done_q, init_done_d;
   logic              grant0, grant1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= INIT;
         cnt_q        <= '0;
         last_grant_q <= 1'b1;
         regwrite_q   <= 1'b0;
         rd_q         <= '0;
         data_q       <= '0;
         init_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         regwrite_q   <= regwrite_d;
         rd_q         <= rd_d;
         data_q       <= data_d;
         init_done_q  <= init_done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (state_q == INIT && cnt_q == LAST_REG) begin
         state_d = RUN;
      end
   end

   always_comb begin
      grant0       = 1'b0;
      grant1       = 1'b0;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      regwrite_d   = 1'b0;
      rd_d         = rd_q;
      data_d       = data_q;
      init_done_d  = init_done_q;
      unique case (state_q)
         INIT: begin
            regwrite_d = 1'b1;
            rd_d       = cnt_q;
            data_d     = INIT_VALUE;
            cnt_d      = cnt_q + 1'b1;
            if (cnt_q == LAST_REG) begin
               init_done_d = 1'b1;
            end
         end
         RUN: begin
            // Under contention the port that did not win last time is served.
            grant0 = wb.req0_valid & (~wb.req1_valid | last_grant_q);
            grant1 = wb.req1_valid & (~wb.req0_valid | ~last_grant_q);
            if (grant0) begin
               rd_d         = wb.req0_rd;
               data_d       = wb.req0_data;
               regwrite_d   = !(ZERO_X0 && wb.req0_rd == '0);
               last_grant_d = 1'b0;
            end else if (grant1) begin
               rd_d         = wb.req1_rd;
               data_d       = wb.req1_data;
               regwrite_d   = !(ZERO_X0 && wb.req1_rd == '0);
               last_grant_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign wb.req0_ready = grant0;
   assign wb.req1_ready = grant1;
   assign rf_RegWrite   = regwrite_q;
   assign rf_RD         = rd_q;
   assign rf_WriteData  = data_q;
   assign init_done     = init_done_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler: init sweep, reset abort, arbitration,
// x0 drop and requests pending across the INIT/RUN boundary.
module tb_regfile_write_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        rf_RegWrite;
   logic [4:0]  rf_RD;
   logic [63:0] rf_WriteData;
   logic        init_done;

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;

   regfile_write_scheduler_if #(.DATA_W(64), .ADDR_W(5)) wb ();

   regfile_write_scheduler #(
      .DATA_W(64), .ADDR_W(5), .NREGS(32), .INIT_VALUE(64'h0), .ZERO_X0(1'b1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .wb(wb.slave),
      .rf_RegWrite(rf_RegWrite),
      .rf_RD(rf_RD),
      .rf_WriteData(rf_WriteData),
      .init_done(init_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset         = 1'b0;
      wb.req0_valid = 1'b0;
      wb.req0_rd    = '0;
      wb.req0_data  = '0;
      wb.req1_valid = 1'b0;
      wb.req1_rd    = '0;
      wb.req1_data  = '0;

      tick();
      tick();
      chk("rst_we", rf_RegWrite, 0);
      chk("rst_rd", rf_RD, 0);
      chk("rst_data", rf_WriteData, 0);
      chk("rst_done", init_done, 0);
      reset = 1'b1;

      // Partial sweep, then reset at cnt=10
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("sweep1_rd", rf_RD, i);
      end
      reset = 1'b0;
      tick();
      chk("abort_we", rf_RegWrite, 0);
      chk("abort_rd", rf_RD, 0);
      chk("abort_done", init_done, 0);
      reset = 1'b1;

      // Full sweep with port 0 already requesting
      wb.req0_valid = 1'b1;
      wb.req0_rd    = 5'd9;
      wb.req0_data  = 64'h99;
      for (int i = 0; i < 32; i++) begin
         tick();
         chk("sweep_we", rf_RegWrite, 1);
         chk("sweep_rd", rf_RD, i);
         chk("sweep_data", rf_WriteData, 0);
         chk("sweep_done", init_done, (i == 31) ? 1 : 0);
         #1;
         chk("sweep_rdy0", wb.req0_ready, (i == 31) ? 1 : 0);
         chk("sweep_rdy1", wb.req1_ready, 0);
      end

      tick();
      chk("pend_we", rf_RegWrite, 1);
      chk("pend_rd", rf_RD, 9);
      chk("pend_data", rf_WriteData, 64'h99);

      // Single requester on port 0
      wb.req0_rd   = 5'd5;
      wb.req0_data = 64'hDEAD;
      #1;
      chk("single_rdy0", wb.req0_ready, 1);
      chk("single_rdy1", wb.req1_ready, 0);
      tick();
      chk("single_we", rf_RegWrite, 1);
      chk("single_rd", rf_RD, 5);
      chk("single_data", rf_WriteData, 64'hDEAD);
      wb.req0_valid = 1'b0;
      #1;
      chk("idle_rdy0", wb.req0_ready, 0);
      tick();
      chk("idle_we", rf_RegWrite, 0);
      chk("idle_rd", rf_RD, 5);
      chk("idle_data", rf_WriteData, 64'hDEAD);

      // Port 1 writes x0: accepted but dropped
      wb.req1_valid = 1'b1;
      wb.req1_rd    = 5'd0;
      wb.req1_data  = 64'h7;
      #1;
      chk("x0_rdy1", wb.req1_ready, 1);
      chk("x0_rdy0", wb.req0_ready, 0);
      tick();
      chk("x0_we", rf_RegWrite, 0);

      // Contention: port 1 was last granted, so port 0 goes first
      wb.req0_valid = 1'b1;
      wb.req0_rd    = 5'd1;
      wb.req0_data  = 64'h11;
      wb.req1_valid = 1'b1;
      wb.req1_rd    = 5'd2;
      wb.req1_data  = 64'h22;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("rr_rdy0", wb.req0_ready, (k % 2 == 0) ? 1 : 0);
         chk("rr_rdy1", wb.req1_ready, (k % 2 == 0) ? 0 : 1);
         tick();
         chk("rr_we", rf_RegWrite, 1);
         chk("rr_rd", rf_RD, (k % 2 == 0) ? 1 : 2);
         chk("rr_data", rf_WriteData, (k % 2 == 0) ? 64'h11 : 64'h22);
      end
      wb.req0_valid = 1'b0;
      wb.req1_valid = 1'b0;

      // Reset during RUN restarts init
      reset = 1'b0;
      tick();
      chk("runrst_we", rf_RegWrite, 0);
      chk("runrst_done", init_done, 0);
      reset = 1'b1;
      tick();
      chk("restart_we", rf_RegWrite, 1);
      chk("restart_rd", rf_RD, 0);
      chk("restart_done", init_done, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
